// File: rtl/ps2_keycode_ctrl.sv
// ============================================================================
//  Module      : ps2_keycode_ctrl
//  Description : Assembles PS/2 scan-code bytes (E0/F0 prefixes) into key
//                events and queues them in a FWFT FIFO for the keycode CI.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_keycode_ctrl #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    input  logic                          ps2_read,
    input  logic                          clr_overflow,
    output logic                          event_valid,
    output logic [9:0]                    event_data,
    output logic [$clog2(FIFO_DEPTH):0]   event_count,
    output logic                          overflow
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_EXT     = 2'd1;
    localparam logic [1:0] c_ST_BRK     = 2'd2;
    localparam logic [1:0] c_ST_EXT_BRK = 2'd3;

    logic [1:0]           r_state;
    logic [c_TMO_W-1:0]   r_tmo;
    logic                 r_push;
    logic [9:0]           r_push_data;
    logic                 r_pop;

    logic [9:0]           r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic [9:0]           r_head;
    logic                 r_valid;
    logic                 r_ovf;

    logic                 w_is_err;
    logic                 w_do_pop;
    logic                 w_do_push;
    logic                 w_drop;
    logic [c_PTR_W-1:0]   w_rd_next;
    logic [c_PTR_W:0]     w_count_next;
    logic [9:0]           w_head_next;

    assign w_is_err = (rx_data == 8'h00) || (rx_data == 8'hFF);

    // Assembler: emits a registered push request one cycle after the final byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_tmo       <= '0;
            r_push      <= 1'b0;
            r_push_data <= 10'h000;
            r_pop       <= 1'b0;
        end else begin
            r_push <= 1'b0;
            r_pop  <= ps2_read;
            if (rx_valid) begin
                r_tmo <= '0;
                if (w_is_err) begin
                    r_state <= c_ST_IDLE;
                end else begin
                    case (r_state)
                        c_ST_IDLE: begin
                            if (rx_data == 8'hE0)      r_state <= c_ST_EXT;
                            else if (rx_data == 8'hF0) r_state <= c_ST_BRK;
                            else begin
                                r_push      <= 1'b1;
                                r_push_data <= {2'b00, rx_data};
                            end
                        end
                        c_ST_EXT: begin
                            if (rx_data == 8'hF0)      r_state <= c_ST_EXT_BRK;
                            else if (rx_data != 8'hE0) begin
                                r_push      <= 1'b1;
                                r_push_data <= {2'b10, rx_data};
                                r_state     <= c_ST_IDLE;
                            end
                        end
                        c_ST_BRK: begin
                            if (rx_data == 8'hE0)      r_state <= c_ST_EXT_BRK;
                            else if (rx_data != 8'hF0) begin
                                r_push      <= 1'b1;
                                r_push_data <= {2'b01, rx_data};
                                r_state     <= c_ST_IDLE;
                            end
                        end
                        default: begin
                            if ((rx_data != 8'hE0) && (rx_data != 8'hF0)) begin
                                r_push      <= 1'b1;
                                r_push_data <= {2'b11, rx_data};
                                r_state     <= c_ST_IDLE;
                            end
                        end
                    endcase
                end
            end else if (r_state != c_ST_IDLE) begin
                if (r_tmo == c_TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    r_state <= c_ST_IDLE;
                    r_tmo   <= '0;
                end else begin
                    r_tmo <= r_tmo + c_TMO_W'(1);
                end
            end else begin
                r_tmo <= '0;
            end
        end
    end

    assign w_do_pop  = r_pop && (r_count != '0);
    assign w_do_push = r_push && ((r_count != (c_PTR_W + 1)'(FIFO_DEPTH)) || w_do_pop);
    assign w_drop    = r_push && !w_do_push;
    assign w_rd_next = w_do_pop ? (r_rd_ptr + c_PTR_W'(1)) : r_rd_ptr;

    // Next head must see an entry written this same cycle when it becomes the head.
    always_comb begin
        w_count_next = r_count;
        if (w_do_push && !w_do_pop)      w_count_next = r_count + (c_PTR_W + 1)'(1);
        else if (w_do_pop && !w_do_push) w_count_next = r_count - (c_PTR_W + 1)'(1);

        w_head_next = 10'h000;
        if (w_count_next != '0) begin
            if (w_do_push && (w_rd_next == r_wr_ptr)) w_head_next = r_push_data;
            else                                      w_head_next = r_mem[w_rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= r_push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= 10'h000;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_head   <= w_head_next;
            r_valid  <= (w_count_next != '0);
            if (w_drop)            r_ovf <= 1'b1;
            else if (clr_overflow) r_ovf <= 1'b0;
        end
    end

    assign event_valid = r_valid;
    assign event_data  = r_head;
    assign event_count = r_count;
    assign overflow    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keycode_ctrl.sv
// ============================================================================
//  Module      : tb_ps2_keycode_ctrl
//  Description : Self-checking bench for ps2_keycode_ctrl (directed table,
//                corner sequences, randomized traffic vs. reference model).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_keycode_ctrl;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       ps2_read = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       event_valid;
    logic [9:0] event_data;
    logic [3:0] event_count;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    ps2_keycode_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .ps2_read     (ps2_read),
        .clr_overflow (clr_overflow),
        .event_valid  (event_valid),
        .event_data   (event_data),
        .event_count  (event_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: event queue plus prefix flags, one-cycle request delay.
    logic [9:0] m_q[$];
    bit         m_ext, m_brk, m_ovf;
    int         m_idle;
    bit         m_pend_push, m_pend_pop;
    logic [9:0] m_pend_data;

    task automatic model_step(input bit rs, input bit rv, input logic [7:0] d,
                              input bit rd, input bit clr);
        int  was;
        bit  dpop, dpush;
        if (rs) begin
            m_q.delete();
            m_ext = 0; m_brk = 0; m_ovf = 0; m_idle = 0;
            m_pend_push = 0; m_pend_pop = 0; m_pend_data = '0;
            return;
        end
        was   = m_q.size();
        dpop  = m_pend_pop && (was > 0);
        dpush = m_pend_push && ((was < DEPTH) || dpop);
        if (dpop)  void'(m_q.pop_front());
        if (dpush) m_q.push_back(m_pend_data);
        if (m_pend_push && !dpush) m_ovf = 1;
        else if (clr)              m_ovf = 0;
        m_pend_pop  = rd;
        m_pend_push = 0;
        if (rv) begin
            m_idle = 0;
            if (d == 8'h00 || d == 8'hFF) begin
                m_ext = 0; m_brk = 0;
            end else if (d == 8'hE0) begin
                m_ext = 1;
            end else if (d == 8'hF0) begin
                m_brk = 1;
            end else begin
                m_pend_push = 1;
                m_pend_data = {m_ext, m_brk, d};
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_ext = 0; m_brk = 0; m_idle = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [9:0] hd;
        hd = (m_q.size() > 0) ? m_q[0] : 10'h000;
        check({tag, " valid"}, {31'd0, event_valid}, {31'd0, m_q.size() > 0});
        check({tag, " data"},  {22'd0, event_data},  {22'd0, hd});
        check({tag, " count"}, {28'd0, event_count}, m_q.size());
        check({tag, " ovf"},   {31'd0, overflow},    {31'd0, m_ovf});
    endtask

    task automatic cycle(input bit rs, input bit rv, input logic [7:0] d,
                         input bit rd, input bit clr, input string tag);
        @(negedge clk);
        reset = rs; rx_valid = rv; rx_data = d; ps2_read = rd; clr_overflow = clr;
        @(posedge clk);
        model_step(rs, rv, d, rd, clr);
        #1;
        check_model(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 0, 0, tag);
    endtask

    typedef struct packed {
        logic       rs;
        logic       rv;
        logic [7:0] d;
        logic       rd;
        logic       clr;
        logic       ev;
        logic [9:0] ed;
        logic [3:0] ec;
        logic       ov;
    } vec_t;

    vec_t tbl[28];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 10'h01C, 4'd1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 10'h01C, 4'd1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'hE0, 1'b0, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'h75, 1'b0, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 10'h375, 4'd1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'hE0, 1'b0, 1'b0, 1'b1, 10'h375, 4'd1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 10'h375, 4'd1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 10'h375, 4'd1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 10'h375, 4'd2, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 10'h01C, 4'd1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 10'h01C, 4'd1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 8'hE0, 1'b0, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 10'h01C, 4'd1, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 10'h01C, 4'd1, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0};
        tbl[22] = '{1'b1, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0};
        tbl[23] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0};
        tbl[24] = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0};
        tbl[25] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 10'h005, 4'd1, 1'b0};
        tbl[26] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0};
        tbl[27] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0};

        for (int i = 0; i < 28; i++) begin
            cycle(tbl[i].rs, tbl[i].rv, tbl[i].d, tbl[i].rd, tbl[i].clr, $sformatf("vec%0d", i));
            check($sformatf("vec%0d tbl_valid", i), {31'd0, event_valid}, {31'd0, tbl[i].ev});
            check($sformatf("vec%0d tbl_data", i),  {22'd0, event_data},  {22'd0, tbl[i].ed});
            check($sformatf("vec%0d tbl_count", i), {28'd0, event_count}, {28'd0, tbl[i].ec});
            check($sformatf("vec%0d tbl_ovf", i),   {31'd0, overflow},    {31'd0, tbl[i].ov});
        end

        // Abandoned break prefix: plain make code afterwards.
        cycle(0, 1, 8'hF0, 0, 0, "tmo");
        idle(TIMEOUT, "tmo");
        cycle(0, 1, 8'h1C, 0, 0, "tmo");
        idle(1, "tmo");
        check("timeout_plain", {22'd0, event_data}, 32'h01C);
        cycle(0, 0, 8'h00, 1, 0, "tmo");
        idle(1, "tmo");

        // Prefix still alive shortly before the timeout.
        cycle(0, 1, 8'hF0, 0, 0, "pre_tmo");
        idle(TIMEOUT - 2, "pre_tmo");
        cycle(0, 1, 8'h1C, 0, 0, "pre_tmo");
        idle(1, "pre_tmo");
        check("pre_timeout_break", {22'd0, event_data}, 32'h11C);
        cycle(0, 0, 8'h00, 1, 0, "pre_tmo");
        idle(1, "pre_tmo");

        // Overflow: nine codes into an eight-deep queue.
        for (int k = 1; k <= DEPTH + 1; k++) cycle(0, 1, 8'(k), 0, 0, "ovf_fill");
        idle(2, "ovf_fill");
        check("ovf_count", {28'd0, event_count}, 32'd8);
        check("ovf_flag",  {31'd0, overflow},    32'd1);
        for (int k = 1; k <= DEPTH; k++) begin
            check($sformatf("ovf_pop%0d", k), {22'd0, event_data}, k);
            cycle(0, 0, 8'h00, 1, 0, "ovf_pop");
            idle(1, "ovf_pop");
        end
        check("ovf_empty", {28'd0, event_count}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        cycle(0, 0, 8'h00, 0, 1, "ovf_clr");
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Full queue with simultaneous push and pop.
        for (int k = 0; k < DEPTH; k++) cycle(0, 1, 8'h10 + 8'(k), 0, 0, "full");
        idle(2, "full");
        cycle(0, 1, 8'h20, 1, 0, "full_pp");
        idle(1, "full_pp");
        check("full_pp_count", {28'd0, event_count}, 32'd8);
        check("full_pp_head",  {22'd0, event_data},  32'h011);
        check("full_pp_ovf",   {31'd0, overflow},    32'd0);
        for (int k = 0; k < DEPTH + 1; k++) cycle(0, 0, 8'h00, 1, 0, "drain");
        idle(2, "drain");
        check("drain_empty", {28'd0, event_count}, 32'd0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 4000; n++) begin
            bit         rs, rv, rd, clr;
            logic [7:0] d;
            int         sel;
            bit         quiet;
            quiet = ((n % 300) > 270);
            rs  = ($urandom_range(0, 299) == 0);
            rv  = !quiet && ($urandom_range(0, 99) < 40);
            rd  = ($urandom_range(0, 99) < 25);
            clr = ($urandom_range(0, 99) < 5);
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    d = 8'hE0;
                2, 3:    d = 8'hF0;
                4:       d = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
                5:       d = ($urandom_range(0, 1) != 0) ? 8'hE1 : 8'hAA;
                default: d = 8'($urandom_range(1, 254));
            endcase
            cycle(rs, rv, d, rd, clr, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
